if_stage: RTL and testbench

- Fetch stage of the MIPS pipeline: owns the program counter, computes next-PC, and registers the fetched word into the IF/ID latch for the decoder.
- Drives `pc` into the combinational instruction memory and receives `ins_in` back in the same cycle.
- Branch, jump and jr redirects are resolved in ID and fed back here. One architectural delay slot.

---
 rtl/if_stage.sv | 72 +++++++
 tb/tb_if_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// MIPS fetch stage: owns the PC, selects the next fetch address from ID's
// redirect request, and registers the fetched word into the IF/ID latch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] jr_target,
  input  logic [31:0] ins_in,
  output logic [31:0] pc,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_adel
);

  // One past the last legal fetch address; 33 bits so the bound cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  logic [31:0] npc;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic        adel_if;

  // Redirect targets are relative to id_pc, so the word now in IF is the delay slot.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    br_target = id_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    npc       = pc_plus4;
    case (npc_sel)
      2'd1:    npc = br_taken ? br_target : pc_plus4;
      2'd2:    npc = {id_pc[31:28], index26, 2'b00};
      2'd3:    npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

  assign adel_if = (pc[1:0] != 2'b00) || (pc < RESET_PC) || ({1'b0, pc} >= IM_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      id_ins   <= '0;
      id_pc    <= RESET_PC;
      id_pc8   <= RESET_PC + 32'd8;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (!stall) begin
      pc     <= npc;
      id_pc  <= pc;
      id_pc8 <= pc + 32'd8;
      if (flush) begin
        id_ins   <= '0;
        id_valid <= 1'b0;
        id_adel  <= 1'b0;
      end else begin
        id_ins   <= adel_if ? '0 : ins_in;
        id_valid <= 1'b1;
        id_adel  <= adel_if;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async reset check, then random
// traffic compared against an arithmetic model of the fetch rules.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, br_taken;
  logic [1:0]  npc_sel;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] jr_target, ins_in;
  logic [31:0] pc, id_ins, id_pc, id_pc8;
  logic        id_valid, id_adel;

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .npc_sel(npc_sel), .br_taken(br_taken), .imm16(imm16),
    .index26(index26), .jr_target(jr_target), .ins_in(ins_in),
    .pc(pc), .id_ins(id_ins), .id_pc(id_pc), .id_pc8(id_pc8),
    .id_valid(id_valid), .id_adel(id_adel)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: a distinct word per address.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  assign ins_in = im_word(pc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                           input logic [31:0] e_idpc, input logic [31:0] e_pc8,
                           input logic e_valid, input logic e_adel);
    check({tag, ".pc"},       pc,       e_pc);
    check({tag, ".id_ins"},   id_ins,   e_ins);
    check({tag, ".id_pc"},    id_pc,    e_idpc);
    check({tag, ".id_pc8"},   id_pc8,   e_pc8);
    check({tag, ".id_valid"}, 32'(id_valid), 32'(e_valid));
    check({tag, ".id_adel"},  32'(id_adel),  32'(e_adel));
  endtask

  typedef struct {
    logic        st, fl;
    logic [1:0]  sel;
    logic        tk;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jrt;
    logic [31:0] e_pc, e_idpc;
    logic        e_valid, e_adel;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic fl, input logic [1:0] sel,
                              input logic tk, input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] jrt, input logic [31:0] e_pc,
                              input logic [31:0] e_idpc, input logic e_valid, input logic e_adel);
    vec_t v;
    v.st = st; v.fl = fl; v.sel = sel; v.tk = tk; v.imm = imm; v.idx = idx; v.jrt = jrt;
    v.e_pc = e_pc; v.e_idpc = e_idpc; v.e_valid = e_valid; v.e_adel = e_adel;
    return v;
  endfunction

  // Behavioural reference state for the random phase.
  logic [31:0] m_pc, m_ins, m_idpc, m_pc8;
  logic        m_valid, m_adel;

  function automatic logic fetch_fault(input logic [31:0] a);
    longint unsigned x = longint'(a);
    return (x % 4 != 0) || (x < longint'(RESET_PC)) ||
           (x >= longint'(RESET_PC) + 4 * longint'(IM_WORDS));
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_ins = '0; m_idpc = RESET_PC; m_pc8 = RESET_PC + 8;
    m_valid = 1'b0; m_adel = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    logic        f;
    if (stall) return;
    case (npc_sel)
      2'd1:    nxt = br_taken ? 32'(int'(m_idpc) + 4 + 4 * int'($signed(imm16))) : m_pc + 4;
      2'd2:    nxt = (m_idpc & 32'hF000_0000) | (32'(index26) * 4);
      2'd3:    nxt = jr_target;
      default: nxt = m_pc + 4;
    endcase
    f = fetch_fault(m_pc);
    if (flush) begin
      m_ins = '0; m_valid = 1'b0; m_adel = 1'b0;
    end else begin
      m_ins = f ? '0 : im_word(m_pc); m_valid = 1'b1; m_adel = f;
    end
    m_idpc = m_pc;
    m_pc8  = m_pc + 8;
    m_pc   = nxt;
  endtask

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // sel jr/jump fields default to harmless values when unused.
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3004, 32'h3000, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3008, 32'h3004, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h300C, 32'h3008, 1, 0));
    tbl.push_back(mk(0,0,1,1,16'hFFFE,26'h0,32'h0, 32'h3004, 32'h300C, 1, 0));
    tbl.push_back(mk(0,0,1,0,16'hFFFE,26'h0,32'h0, 32'h3008, 32'h3004, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h300C, 32'h3008, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3010, 32'h300C, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3014, 32'h3010, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3018, 32'h3014, 1, 0));
    tbl.push_back(mk(0,0,2,0,16'h0,26'h0000C03,32'h0, 32'h300C, 32'h3018, 1, 0));
    tbl.push_back(mk(0,0,3,0,16'h0,26'h0,32'h3000, 32'h3000, 32'h300C, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,2,0,16'h0,26'h0000C05,32'h0, 32'h3000, 32'h300C, 1, 0));
    tbl.push_back(mk(0,1,2,0,16'h0,26'h0000C05,32'h0, 32'h3014, 32'h3000, 0, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3018, 32'h3014, 1, 0));
    tbl.push_back(mk(0,0,3,0,16'h0,26'h0,32'h3002, 32'h3002, 32'h3018, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3006, 32'h3002, 1, 1));
    tbl.push_back(mk(0,0,3,0,16'h0,26'h0,32'h3000, 32'h3000, 32'h3006, 1, 1));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3004, 32'h3000, 1, 0));
    tbl.push_back(mk(0,0,3,0,16'h0,26'h0,32'h4000, 32'h4000, 32'h3004, 1, 0));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h4004, 32'h4000, 1, 1));
    tbl.push_back(mk(0,0,3,0,16'h0,26'h0,32'h3FFC, 32'h3FFC, 32'h4004, 1, 1));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h4000, 32'h3FFC, 1, 0));
    tbl.push_back(mk(0,0,3,0,16'h0,26'h0,32'h2FFC, 32'h2FFC, 32'h4000, 1, 1));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3000, 32'h2FFC, 1, 1));
    tbl.push_back(mk(0,0,0,0,16'h0,26'h0,32'h0, 32'h3004, 32'h3000, 1, 0));

    reset = 1'b0; stall = 0; flush = 0; npc_sel = 0; br_taken = 0;
    imm16 = '0; index26 = '0; jr_target = '0;
    #12;
    check_all("reset", 32'h3000, 32'h0, 32'h3000, 32'h3008, 0, 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      stall = tbl[i].st; flush = tbl[i].fl; npc_sel = tbl[i].sel; br_taken = tbl[i].tk;
      imm16 = tbl[i].imm; index26 = tbl[i].idx; jr_target = tbl[i].jrt;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_pc,
                (tbl[i].e_valid && !tbl[i].e_adel) ? im_word(tbl[i].e_idpc) : 32'h0,
                tbl[i].e_idpc, tbl[i].e_idpc + 32'd8, tbl[i].e_valid, tbl[i].e_adel);
    end

    // Asynchronous reset between edges while a flush/jump is being requested.
    stall = 0; flush = 1; npc_sel = 2; index26 = 26'h0000C05;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_all("async_reset", 32'h3000, 32'h0, 32'h3000, 32'h3008, 0, 0);
    @(posedge clk); #1;
    check_all("reset_hold", 32'h3000, 32'h0, 32'h3000, 32'h3008, 0, 0);
    reset = 1'b1;
    model_reset();

    for (int n = 0; n < 300; n++) begin
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 6) == 0);
      npc_sel  = 2'($urandom_range(0, 3));
      br_taken = 1'($urandom);
      imm16    = 16'($signed($urandom_range(0, 64)) - 32);
      index26  = 26'((32'h3000 + 4 * $urandom_range(0, 1100)) >> 2);
      jr_target = 32'h3000 + $urandom_range(0, 32'h1100);
      if ($urandom_range(0, 7) == 0) jr_target = jr_target | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) index26 = 26'($urandom);
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_pc, m_ins, m_idpc, m_pc8, m_valid, m_adel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
